smpl_toggle_ctrl: RTL and testbench
===================================

Name: smpl_toggle_ctrl

Overview:
- Controller that sequences the a/b toggle datapath.
- On a start request it drives a programmable burst of N toggles on a, with b as a one-cycle-delayed copy of a.
- Supports a hold input that freezes toggling without losing progress, and an abort input.
- Reports busy, a done pulse and the remaining count; sits between the test stimulus layer and the toggle datapath it owns.

Parameters:
- LEN_W, 4: width of the burst-length and remaining-count fields; max burst is 2**LEN_W-1 toggles.

Ports:
- clk        input   1      clock; all state updates on posedge
- rst        input   1      synchronous reset, active-high
- start      input   1      burst request; sampled only in IDLE
- len        input   LEN_W  burst length in toggles; captured with start
- hold       input   1      freeze toggling while high
- abort      input   1      terminate burst, return to IDLE
- a          output  1      toggle output
- b          output  1      a delayed by one clock
- busy       output  1      high in RUN or HOLD
- done       output  1      one-cycle pulse at normal burst completion
- remaining  output  LEN_W  toggles still to perform

Behaviour:
Interface:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset has priority over every other input in any state.

Reset values:
- State IDLE; a=0, b=0, busy=0, done=0, remaining=0.

b path:
- b <= a on every edge, independent of state; reset forces b=0.

States: IDLE, RUN, HOLD, DONE. Outputs are decoded from registered state: busy = RUN|HOLD, done = DONE.

IDLE:
- start=1, len!=0: remaining<=len, next RUN. No toggle on this edge.
- start=1, len==0: next DONE (done pulse, zero toggles), remaining stays 0.
- start=0: stay.

RUN, evaluated in priority order:
- abort: next IDLE, remaining<=0, no toggle, no done.
- hold: next HOLD, no toggle.
- Otherwise: a<=!a and remaining<=remaining-1. If remaining==1, next DONE, else stay RUN.

HOLD:
- abort: next IDLE, remaining<=0.
- hold=0: next RUN, no toggle on this edge.
- hold=1: stay; a and remaining frozen.

DONE:
- Lasts one cycle, then next IDLE unconditionally.
- start and abort are ignored in DONE.

Sequencing rules:
- start is ignored in RUN/HOLD/DONE; no queuing.
- Timing example: start sampled at edge k with len=N and no hold gives toggles at edges k+1..k+N, done high in cycle k+N..k+N+1, and IDLE at edge k+N+1.
- Parity: after a completed burst, a = a_before ^ N[0]. a keeps its value across bursts and abort; only rst clears it.
- remaining never underflows. remaining==0 whenever state is IDLE or DONE.
- abort and hold together: abort wins.
- rst during RUN/HOLD/DONE: next IDLE with all reset values; no done pulse.

Embedded assertions (same clock, disabled during rst):
- b equals $past(a).
- In RUN without hold or abort, a toggles.
- done implies !busy.
- remaining==0 in IDLE.

Decomposition:
- Package smpl_ctrl_pkg: state enum (IDLE, RUN, HOLD, DONE) and the LEN_W default constant.
- Sub-module smpl_toggle_dp:
  - inputs clk, rst, tgl;
  - outputs a, b;
  - holds the a/b registers, with a toggling when tgl=1 and b <= a.
- The controller holds the FSM and the remaining counter, and drives tgl.

Test Plan:
- Basic burst: rst for 2 cycles, then start with len=3 at edge 5. Require a toggles at edges 6, 7, 8 (a=1, 0, 1), remaining 3→2→1→0, done high only in cycle 8..9, busy high for cycles 5..8, and b one cycle behind a.
- Zero length: start with len=0. Require a single done pulse on the next cycle, busy never high, and a unchanged.
- Hold: start with len=4, then hold high for 3 cycles after the 2nd toggle. Require a and remaining(=2) frozen during hold, no toggle on the release edge, and done 3 cycles after release.
- Abort: start with len=10, abort after 4 toggles with hold also high. Require IDLE next cycle, remaining=0, no done pulse, and a=0 retained.
- Reset mid-burst: rst at the 2nd toggle of a len=5 burst. Require a=b=0, busy=0, done=0 next edge; a following start with len=1 produces one toggle and done.
- Start ignored: pulse start with len=7 during RUN (first burst len=2) and during DONE. Require exactly 2 toggles total and a final a of 0.

Source files
------------

// File: rtl/smpl_ctrl_pkg.sv
// Shared types and constants for the toggle burst controller.
package smpl_ctrl_pkg;

   // Default width of the burst-length / remaining-count fields.
   localparam int LEN_W_DEF = 4;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // True for the states in which a burst is in progress.
   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

   // True for the single-cycle completion state.
   function automatic logic is_done(input state_t s);
      return (s == ST_DONE);
   endfunction

endpackage

// File: rtl/smpl_toggle_chk.sv
// Concurrent property checks for the toggle burst controller.
module smpl_toggle_chk
   import smpl_ctrl_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input logic             clk,
   input logic             rst,
   input logic             hold,
   input logic             abort,
   input state_t           state,
   input logic             a,
   input logic             b,
   input logic             busy,
   input logic             done,
   input logic [LEN_W-1:0] remaining
);

   // Marks that the previous edge was outside reset, so $past(a) is meaningful.
   logic past_ok_r;

   // Tracks whether the last sampled edge had reset released.
   always_ff @(posedge clk) begin
      if (rst) begin
         past_ok_r <= 1'b0;
      end else begin
         past_ok_r <= 1'b1;
      end
   end

   b_follows_a: assert property (@(posedge clk) disable iff (rst || !past_ok_r)
      b == $past(a));

   run_toggles: assert property (@(posedge clk) disable iff (rst)
      (state == ST_RUN && !hold && !abort) |=> (a != $past(a)));

   done_not_busy: assert property (@(posedge clk) disable iff (rst)
      done |-> !busy);

   idle_rem_zero: assert property (@(posedge clk) disable iff (rst)
      (state == ST_IDLE) |-> (remaining == {LEN_W{1'b0}}));

endmodule

// File: rtl/smpl_toggle_dp.sv
// Toggle datapath: a flips when tgl is set, b follows a one clock later.
module smpl_toggle_dp (
   input  logic clk,
   input  logic rst,
   input  logic tgl,
   output logic a,
   output logic b
);

   logic a_r;
   logic b_r;

   // a register: flips on tgl, otherwise keeps its value (only rst clears it).
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r <= 1'b0;
      end else if (tgl) begin
         a_r <= ~a_r;
      end else begin
         a_r <= a_r;
      end
   end

   // b register: one-cycle delayed copy of a, independent of controller state.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_r <= 1'b0;
      end else begin
         b_r <= a_r;
      end
   end

   assign a = a_r;
   assign b = b_r;

endmodule

// File: rtl/smpl_toggle_ctrl.sv
// Burst controller: sequences N toggles on the owned a/b datapath with hold/abort.
module smpl_toggle_ctrl
   import smpl_ctrl_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             hold,
   input  logic             abort,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] remaining
);

   localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           next_state_s;
   logic [LEN_W-1:0] rem_r;
   logic [LEN_W-1:0] rem_next_s;
   logic             tgl_s;
   logic             busy_r;
   logic             done_r;

   // Next-state, next-count and toggle-enable decode.
   always_comb begin
      next_state_s = state_r;
      rem_next_s   = rem_r;
      tgl_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (len != REM_ZERO) begin
                  rem_next_s   = len;
                  next_state_s = ST_RUN;
               end else begin
                  // Zero-length burst: report completion with no toggles.
                  rem_next_s   = REM_ZERO;
                  next_state_s = ST_DONE;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               rem_next_s   = REM_ZERO;
               next_state_s = ST_IDLE;
            end else if (hold) begin
               next_state_s = ST_HOLD;
            end else if (rem_r == REM_ZERO) begin
               // Cannot occur in normal operation; bail out rather than underflow.
               next_state_s = ST_IDLE;
            end else begin
               tgl_s      = 1'b1;
               rem_next_s = rem_r - REM_ONE;
               if (rem_r == REM_ONE) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_RUN;
               end
            end
         end
         ST_HOLD: begin
            if (abort) begin
               rem_next_s   = REM_ZERO;
               next_state_s = ST_IDLE;
            end else if (!hold) begin
               // Release edge resumes RUN without toggling.
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_HOLD;
            end
         end
         ST_DONE: begin
            rem_next_s   = REM_ZERO;
            next_state_s = ST_IDLE;
         end
         default: begin
            rem_next_s   = REM_ZERO;
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State and remaining-count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rem_r   <= REM_ZERO;
      end else begin
         state_r <= next_state_s;
         rem_r   <= rem_next_s;
      end
   end

   // Status flags registered alongside the state they decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= is_busy(next_state_s);
         done_r <= is_done(next_state_s);
      end
   end

   smpl_toggle_dp u_dp (
      .clk (clk),
      .rst (rst),
      .tgl (tgl_s),
      .a   (a),
      .b   (b)
   );

   smpl_toggle_chk #(
      .LEN_W (LEN_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .abort     (abort),
      .state     (state_r),
      .a         (a),
      .b         (b),
      .busy      (busy_r),
      .done      (done_r),
      .remaining (rem_r)
   );

   assign busy      = busy_r;
   assign done      = done_r;
   assign remaining = rem_r;

endmodule

// File: tb/tb_smpl_toggle_ctrl.sv
// Directed scoreboard bench for smpl_toggle_ctrl.
module tb_smpl_toggle_ctrl;

   localparam int LEN_W = 4;

   typedef struct packed {
      logic             a;
      logic             b;
      logic             busy;
      logic             done;
      logic [LEN_W-1:0] rem;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             hold;
   logic             abort;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] remaining;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   step_no;

   smpl_toggle_ctrl #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .hold      (hold),
      .abort     (abort),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every negedge, compare DUT outputs with the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks = checks + 1;
         if (a !== e.a || b !== e.b || busy !== e.busy || done !== e.done || remaining !== e.rem) begin
            errors = errors + 1;
            $display("FAIL step%0d: got a=%b b=%b busy=%b done=%b rem=%0d, want a=%b b=%b busy=%b done=%b rem=%0d",
                     checks, a, b, busy, done, remaining, e.a, e.b, e.busy, e.done, e.rem);
         end
      end
   end

   // Drive one clock of inputs, then queue the outputs expected after that edge.
   task automatic step(input logic r, input logic s, input int l, input logic h, input logic ab,
                       input logic ea, input logic eb, input logic ebusy, input logic edone, input int erem);
      exp_t e;
      @(negedge clk);
      rst   = r;
      start = s;
      len   = LEN_W'(l);
      hold  = h;
      abort = ab;
      @(posedge clk);
      e.a    = ea;
      e.b    = eb;
      e.busy = ebusy;
      e.done = edone;
      e.rem  = LEN_W'(erem);
      exp_q.push_back(e);
      step_no = step_no + 1;
   endtask

   initial begin
      int budget;
      checks  = 0;
      errors  = 0;
      step_no = 0;
      rst = 1'b1; start = 1'b0; len = '0; hold = 1'b0; abort = 1'b0;

      //    rst  st len hl ab   a  b  bsy dn rem
      // Reset state
      step(1'b1,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b1,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      // Basic burst, len=3
      step(1'b0,1'b1, 3,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 3);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 2);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0, 1);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 0);
      // Zero length
      step(1'b0,1'b1, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 0);
      // Hold after 2nd toggle of len=4
      step(1'b0,1'b1, 4,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0, 4);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0, 3);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 2);
      step(1'b0,1'b0, 0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 2);
      step(1'b0,1'b0, 0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 2);
      step(1'b0,1'b0, 0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 2);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0, 2);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0, 1);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 0);
      // Abort (with hold) after 4 toggles of len=10, from a cleared a
      step(1'b1,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b1,10,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,10);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 9);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0, 8);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 7);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0, 6);
      step(1'b0,1'b0, 0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      // Reset at 2nd toggle of len=5, then len=1
      step(1'b0,1'b1, 5,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 5);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 4);
      step(1'b1,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b1, 1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 1);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 0);
      // Start ignored in RUN and DONE (burst len=2 from a cleared a)
      step(1'b1,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b1, 2,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 2);
      step(1'b0,1'b1, 7,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 1);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, 0);
      step(1'b0,1'b1, 7,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0);
      // Abort from HOLD
      step(1'b0,1'b1, 3,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 3);
      step(1'b0,1'b0, 0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0, 3);
      step(1'b0,1'b0, 0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 0);
      // Abort ignored in DONE
      step(1'b0,1'b1, 1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 1);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 0);
      step(1'b0,1'b0, 0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0, 0);
      step(1'b0,1'b0, 0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 0);

      // Let the monitor drain the scoreboard, with a bounded wait.
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget = budget + 1;
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      if (checks != step_no) begin
         errors = errors + 1;
         $display("FAIL count: monitor compared %0d, want %0d", checks, step_no);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
